dmem_access_seq: RTL and testbench
==================================

Name: dmem_access_seq

Overview:
- Sequences data-memory accesses for the MIPS core against a multi-cycle data memory with a req/ack handshake.
- Takes the decoder's load/store strobes and the ALU address, and issues one memory transaction per load/store instruction.
- Holds `stall_o` so the PC and register file freeze until the transaction completes.
- Returns the read data tagged as integer or FP destination.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TO_W, 8, width of the timeout counter; timeout limit is 2^TO_W-1 cycles.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_read_i  input  1  decoder MemRead for the current instruction
- mem_write_i  input  1  decoder MemWrite for the current instruction
- fp_i  input  1  decoder Load_store_fp (FP register file target/source)
- addr_i  input  ADDR_W  effective address from ALU
- wdata_i  input  DATA_W  store data (integer or FP reg, muxed upstream)
- dmem_req_o  output  1  request to memory, held high until ack
- dmem_we_o  output  1  1 = write, 0 = read; valid while req
- dmem_addr_o  output  ADDR_W  registered address; valid while req
- dmem_wdata_o  output  DATA_W  registered store data
- dmem_ack_i  input  1  memory completion, one-cycle pulse
- dmem_rdata_i  input  DATA_W  read data, valid with ack on reads
- stall_o  output  1  freeze PC, regfile and FP regfile writes
- rdata_o  output  DATA_W  captured load data
- rdata_fp_o  output  1  captured fp_i for the load in flight
- rdata_vld_o  output  1  one-cycle commit strobe for load/store completion
- err_o  output  1  one-cycle pulse on timeout (TIMEOUT_EN only)

Behaviour:
- Reset:
  - Asynchronous to IDLE; all outputs 0, including `stall_o`. This holds mid-transaction: `req` drops immediately and any later ack is ignored after reset.
- States: IDLE, REQ, DONE (plus ERR when TIMEOUT_EN is defined).
- IDLE:
  - access = mem_read_i | mem_write_i.
  - If access: `stall_o` = 1 combinationally that same cycle, and the FSM registers addr, wdata, fp and we. `we` = mem_write_i; a write takes priority if both strobes are set.
  - Next state REQ, with `dmem_req_o` = 1 from the next cycle.
- REQ:
  - `dmem_req_o` = 1 and `stall_o` = 1.
  - When `dmem_ack_i` = 1: capture `dmem_rdata_i` into `rdata_o` (reads only; a write leaves `rdata_o` unchanged), drop `req` on the next edge, go to DONE.
- DONE (exactly one cycle):
  - `stall_o` = 0, `rdata_vld_o` = 1, so the core commits the instruction and advances the PC.
  - Next state is always IDLE. Strobes seen in DONE belong to the stalled instruction being committed and are ignored, so there is no re-issue.
- Ack outside REQ is ignored.
- Latency:
  - A load/store costs 1 (IDLE) + N (REQ, N ≥ 1 including the ack cycle) + 1 (DONE) cycles.
  - Non-memory instructions cost 0 stall cycles.
- Back-to-back loads: IDLE is re-entered after DONE, so the next access is detected the cycle after commit.
- `rdata_o` holds its value until the next read ack.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on entry to REQ and increments each REQ cycle without ack.
  - At 2^TO_W-1 with no ack: drop req, go to ERR for one cycle with `err_o` = 1, `rdata_vld_o` = 1, `rdata_o` = 0, `stall_o` = 0, then IDLE.
  - An ack arriving in the same cycle the counter hits the limit wins (normal DONE).
- Undefined:
  - No counter; REQ waits indefinitely.
  - `err_o` is tied to 0.

Decomposition:
- Package dmem_seq_pkg holds:
  - state enum (IDLE, REQ, DONE, ERR);
  - default widths ADDR_W/DATA_W/TO_W;
  - localparam TO_MAX.
- One sub-module, dmem_seq_timer: clear/enable/saturate counter with a `hit` output, instantiated only under TIMEOUT_EN.

Test Plan:
- `mem_read_i`=1, addr 0x100, ack after 3 REQ cycles with rdata 0xDEADBEEF -> `stall_o` high 4 cycles; `rdata_vld_o` pulse with `rdata_o`=0xDEADBEEF; `dmem_we_o`=0 throughout.
- `mem_write_i`=1, fp_i=1, addr 0x200, wdata 0x3F800000, ack in first REQ cycle -> `dmem_we_o`=1 with addr/wdata stable while req; `stall_o` 2 cycles; `rdata_o` unchanged.
- Both strobes set -> write issued (`dmem_we_o`=1).
- Spurious ack in IDLE, then no strobes -> no req, `stall_o`=0, no vld.
- Back-to-back loads 0x10 then 0x14 -> two distinct req phases separated by exactly one DONE + one IDLE cycle, with no duplicate issue.
- rst_n low during REQ -> `dmem_req_o` and `stall_o` go 0 immediately; an ack after reset release is ignored. With TIMEOUT_EN and TO_W=4 and no ack -> `err_o` pulse after 15 REQ cycles, `rdata_o`=0.

Source files
------------

// File: rtl/dmem_seq_pkg.sv
// Shared types and defaults for the data-memory access sequencer.
//   state_e     : sequencer FSM states (ERR is reachable only with TIMEOUT_EN)
//   DEF_*_W     : default address / data / timeout-counter widths
//   TO_MAX      : timeout limit in REQ cycles for the default counter width
package dmem_seq_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TO_W   = 8;
  localparam int TO_MAX     = (1 << DEF_TO_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_seq_timer.sv
// Request timeout counter.
//   clr : zero the count (asserted on entry to REQ)
//   en  : one more REQ cycle went by without an ack
//   hit : this enabled cycle is the (2^TO_W-1)-th without an ack
// The count saturates at all-ones so it can never wrap back into range.
module dmem_seq_timer
  import dmem_seq_pkg::*;
#(
  parameter int TO_W = DEF_TO_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] LIM = '1;

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LIM)   cnt <= cnt + 1'b1;
  end

  // cnt holds the number of no-ack cycles already elapsed, so the current
  // cycle is the limit-th one when cnt is one short of the limit.
  assign hit = en && (cnt == LIM - 1'b1);

endmodule

// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer for the MIPS core.
// Turns a decoder load/store strobe into one req/ack transaction on a
// multi-cycle data memory, stalling the core until the access commits.
//   mem_read_i/mem_write_i/fp_i/addr_i/wdata_i : instruction-side request
//   dmem_req_o/we_o/addr_o/wdata_o, dmem_ack_i/rdata_i : memory handshake
//   stall_o     : freezes PC and register files while the access is open
//   rdata_o     : last load data (held until the next read ack)
//   rdata_fp_o  : FP-destination tag of the last access
//   rdata_vld_o : one-cycle commit strobe
//   err_o       : one-cycle timeout pulse
// Build option TIMEOUT_EN: adds the TO_W parameter and a request timeout that
// ends a stuck access in ERR. Without it REQ waits forever and err_o is 0.
module dmem_access_seq
  import dmem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef TIMEOUT_EN
  , parameter int TO_W = DEF_TO_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              fp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_fp_o,
  output logic              rdata_vld_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              we_q, fp_q;
  logic              access, issue, to_hit;

  assign access = mem_read_i | mem_write_i;
  assign issue  = (state_q == IDLE) && access;

`ifdef TIMEOUT_EN
  dmem_seq_timer #(.TO_W(TO_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (issue),
    .en    ((state_q == REQ) && !dmem_ack_i),
    .hit   (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access) state_d = REQ;
      // ack is tested first so a same-cycle ack beats the timeout
      REQ:  if (dmem_ack_i)  state_d = DONE;
            else if (to_hit) state_d = ERR;
      // strobes seen here still belong to the committing instruction
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fp_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (issue) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        we_q    <= mem_write_i;   // write wins when both strobes are set
        fp_q    <= fp_i;
      end
      if ((state_q == REQ) && dmem_ack_i && !we_q) rdata_q <= dmem_rdata_i;
      else if ((state_q == REQ) && to_hit)         rdata_q <= '0;
    end
  end

  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  // rst_n gate keeps stall low during reset even while strobes are asserted
  assign stall_o      = rst_n & (issue | (state_q == REQ));
  assign rdata_o      = rdata_q;
  assign rdata_fp_o   = fp_q;
  assign rdata_vld_o  = (state_q == DONE) | (state_q == ERR);
  assign err_o        = (state_q == ERR);

endmodule

// File: tb/tb_dmem_access_seq.sv
module tb_dmem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, fp_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_fp_o, rdata_vld_o, err_o;

  always #5 clk = ~clk;

  dmem_access_seq #(
    .ADDR_W(32), .DATA_W(32)
`ifdef TIMEOUT_EN
    , .TO_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .fp_i(fp_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_fp_o(rdata_fp_o),
    .rdata_vld_o(rdata_vld_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fp;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Commit monitor: every vld pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && rdata_vld_o) begin
      check("vld_with_pending_access", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("commit_rdata", rdata_o, e.rdata);
        check("commit_fp", 32'(rdata_fp_o), 32'(e.fp));
        check("commit_err", 32'(err_o), 32'(e.err));
      end
    end
  end

  // One load/store from strobe to commit. n_ack = REQ cycle carrying the ack;
  // n_ack == 0 means the memory never answers (timeout builds only).
  task automatic access(input logic rd, input logic wr, input logic fp,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int n_ack, input logic [31:0] rval);
    exp_t e;
    int   stall_c = 0, req_c = 0, rq = 0, cyc = 0, exp_req;
    int   req_bad = 0;
    bit   got_vld = 1'b0, first = 1'b1;
    exp_req = (n_ack == 0) ? 15 : n_ack;
    if (n_ack == 0)    model_rdata = '0;
    else if (!wr)      model_rdata = rval;
    e.rdata = model_rdata; e.fp = fp; e.err = (n_ack == 0);
    sb.push_back(e);
    mem_read_i = rd; mem_write_i = wr; fp_i = fp; addr_i = addr; wdata_i = wdata;
    while (!got_vld && cyc < 100) begin
      if (dmem_req_o) begin
        rq++;
        dmem_ack_i   = (n_ack != 0) && (rq == n_ack);
        dmem_rdata_i = dmem_ack_i ? rval : $urandom;
      end else dmem_ack_i = 1'b0;
      @(negedge clk);
      if (first) begin
        check("issue_stall_comb", 32'(stall_o), 32'd1);
        check("issue_no_req_yet", 32'(dmem_req_o), 32'd0);
        first = 1'b0;
      end
      if (stall_o) stall_c++;
      if (dmem_req_o) begin
        req_c++;
        if (dmem_we_o !== wr || dmem_addr_o !== addr || dmem_wdata_o !== wdata) req_bad++;
      end
      if (rdata_vld_o) got_vld = 1'b1;
      @(posedge clk); #1;
      dmem_ack_i = 1'b0;
      // upstream values may move once captured; the request must not
      addr_i = $urandom; wdata_i = $urandom;
      cyc++;
    end
    check("commit_seen", 32'(got_vld), 32'd1);
    check("stall_cycles", 32'(stall_c), 32'(exp_req + 1));
    check("req_cycles", 32'(req_c), 32'(exp_req));
    check("req_fields_stable", 32'(req_bad), 32'd0);
    mem_read_i = 1'b0; mem_write_i = 1'b0; fp_i = 1'b0;
  endtask

  task automatic idle_check(input int n);
    int bad = 0;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (dmem_req_o || stall_o || rdata_vld_o) bad++;
      @(posedge clk); #1;
    end
    check("idle_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    // reset state, with a strobe asserted to prove stall stays low
    mem_read_i = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_vld", 32'(rdata_vld_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_we", 32'(dmem_we_o), 32'd0);
    mem_read_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b1, 32'h200, 32'h3F800000, 1, 32'h11111111);
    access(1'b1, 1'b1, 1'b0, 32'h300, 32'h000055AA, 2, 32'h12345678);

    // spurious ack while idle
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    idle_check(1);
    dmem_ack_i = 1'b0;
    idle_check(3);
    check("rdata_hold_after_spurious", rdata_o, model_rdata);

    // back-to-back loads, then make sure nothing re-issues
    access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2, 32'hA1A1A1A1);
    access(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 1, 32'hB2B2B2B2);
    idle_check(5);
    access(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5, 32'h5A5A0F0F);

    // asynchronous reset in the middle of REQ
    mem_read_i = 1'b1; addr_i = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_req_o), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    mem_read_i = 1'b0;
    sb.delete();
    model_rdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    check("late_ack_no_vld", 32'(rdata_vld_o), 32'd0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    idle_check(3);
    check("late_ack_rdata", rdata_o, 32'd0);

`ifdef TIMEOUT_EN
    access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 4, 32'h87654321);
    access(1'b1, 1'b0, 1'b1, 32'h84, 32'h0, 0, 32'h0);
    check("post_timeout_rdata", rdata_o, 32'd0);
    access(1'b1, 1'b0, 1'b0, 32'h88, 32'h0, 2, 32'h0BADF00D);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
